// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment display path.
//   digit_idx_t         : 2-bit digit index (0 = rightmost digit)
//   nibble_t            : one hex digit
//   NUM_DIGITS          : digits per frame (fixed at 4)
//   DEFAULT_REFRESH_DIV : clock cycles per digit slot (1 kHz/digit at 100 MHz)
// Helper functions pick a nibble out of a 16-bit display word and decide
// whether a digit is a leading zero.
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  localparam int NUM_DIGITS          = 4;
  localparam int DEFAULT_REFRESH_DIV = 100000;

  // Nibble of a 16-bit display word belonging to digit idx.
  function automatic nibble_t select_nibble(input logic [15:0] value,
                                            input digit_idx_t  idx);
    return value[4*idx +: 4];
  endfunction

  // True when digit idx is a leading zero: every nibble from digit 3 down
  // to idx is zero. Digit 0 is never a leading zero so a value of 0 still
  // shows a single "0".
  function automatic logic leading_zero(input logic [15:0] value,
                                        input digit_idx_t  idx);
    logic result;
    case (idx)
      2'd1:    result = (value[15:4]  == 12'h000);
      2'd2:    result = (value[15:8]  == 8'h00);
      2'd3:    result = (value[15:12] == 4'h0);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler
// Divides the system clock down to one tick per digit slot.
// Ports:
//   clk    in  : system clock
//   reset  in  : synchronous active-high reset, clears the count
//   enable in  : count advances only while high; low holds the count
//   tick   out : high in the last cycle of a slot (count == REFRESH_DIV-1)
//                while enable is high
// Parameters:
//   REFRESH_DIV : cycles per slot, must be >= 2
// ---------------------------------------------------------------------------
module refresh_prescaler
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;

  // tick is combinational so the scanner can act on the same edge that
  // wraps the count; a frozen prescaler never ticks.
  assign tick = enable && (count == LAST);

  // Slot counter: 0..REFRESH_DIV-1, held while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
// Time-multiplex controller for a 4-digit seven-segment display.
// Ports:
//   clk         in  : system clock
//   reset       in  : synchronous active-high reset
//   enable      in  : scan enable; low freezes scanning and blanks display
//   value_in    in  : 16-bit display word, digit 0 = [3:0]
//   value_valid in  : single-cycle strobe capturing value_in
//   digit_sel   out : current digit index (to the anode decoder)
//   hex_out     out : nibble of the displayed word for digit_sel
//   blank       out : high forces all segments off
//   frame_done  out : one-cycle pulse as digit 3's slot ends
// Parameters:
//   REFRESH_DIV : clock cycles per digit slot (>= 2)
// Build option:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : when defined, leading-zero digits
//   (all nibbles from 3 down to the digit are zero, digit != 0) are blanked.
//
// New words go into a pending register and only move to the displayed
// (shadow) register at a frame boundary, so a frame never mixes two words.
// ---------------------------------------------------------------------------
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic [1:0]  digit_sel,
  output logic [3:0]  hex_out,
  output logic        blank,
  output logic        frame_done
);

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  logic        tick;
  logic        boundary;
  digit_idx_t  digit_next;
  logic [15:0] shadow, shadow_next;
  logic [15:0] pending, pending_next;
  logic        pending_flag, pending_flag_next;
  nibble_t     hex_next;
  logic        blank_next;

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // Next-state logic. hex_out and blank are computed from the *next*
  // digit index and shadow word so that, once registered, they line up
  // with digit_sel in the same cycle and never show a stale pairing.
  // A strobe landing exactly on the boundary bypasses pending so it is
  // shown in the very next frame.
  always_comb begin
    boundary          = tick && (digit_sel == LAST_DIGIT);
    digit_next        = tick ? (digit_sel + 2'd1) : digit_sel;
    shadow_next       = shadow;
    pending_next      = pending;
    pending_flag_next = pending_flag;

    if (value_valid) begin
      pending_next      = value_in;
      pending_flag_next = 1'b1;
    end

    if (boundary) begin
      if (value_valid) begin
        shadow_next = value_in;
      end else if (pending_flag) begin
        shadow_next = pending;
      end
      pending_flag_next = 1'b0;
    end

    hex_next = select_nibble(shadow_next, digit_next);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    blank_next = !enable || leading_zero(shadow_next, digit_next);
`else
    blank_next = !enable;
`endif
  end

  // State and output registers; reset wins over everything and drops any
  // pending word.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_sel    <= '0;
      hex_out      <= '0;
      blank        <= 1'b0;
      frame_done   <= 1'b0;
      shadow       <= '0;
      pending      <= '0;
      pending_flag <= 1'b0;
    end else begin
      digit_sel    <= digit_next;
      hex_out      <= hex_next;
      blank        <= blank_next;
      frame_done   <= boundary;
      shadow       <= shadow_next;
      pending      <= pending_next;
      pending_flag <= pending_flag_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
// Self-checking bench for seven_seg_scanner with REFRESH_DIV = 4.
// A fixed vector table covers reset and the first frames, hand-written
// sequences cover tear-free update, boundary collision, enable pause and
// (when SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined) leading-zero blanking,
// and a random phase compares against a frame-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        value_valid;
  logic [15:0] value_in;
  logic [1:0]  digit_sel;
  logic [3:0]  hex_out;
  logic        blank;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: enabled-cycle position within the frame plus word state.
  int          m_count;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_flag;
  logic        m_blank;
  logic        m_fd;

  typedef struct {
    logic        rst;
    logic        en;
    logic        vv;
    logic [15:0] val;
    int          reps;
    logic [1:0]  dig;
    logic [3:0]  hex;
    logic        bl_def;
    logic        bl_lz;
    logic        fd;
  } vec_t;

  vec_t vecs[12];

  seven_seg_scanner #(
    .REFRESH_DIV(R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value_in   (value_in),
    .value_valid(value_valid),
    .digit_sel  (digit_sel),
    .hex_out    (hex_out),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  function automatic logic lzModel(input logic [15:0] s, input int d);
    return (d != 0) && ((s >> (4 * d)) == 16'h0000);
  endfunction
`endif

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic modelEdge();
    logic tk;
    logic bnd;
    if (reset) begin
      m_count  = 0;
      m_shadow = 16'h0;
      m_pend   = 16'h0;
      m_flag   = 1'b0;
      m_blank  = 1'b0;
      m_fd     = 1'b0;
    end else begin
      tk  = enable && ((m_count % R) == R - 1);
      bnd = tk && ((m_count / R) == 3);
      if (enable) m_count = (m_count + 1) % (4 * R);
      if (bnd) begin
        if (value_valid) m_shadow = value_in;
        else if (m_flag) m_shadow = m_pend;
        m_flag = 1'b0;
      end else if (value_valid) begin
        m_pend = value_in;
        m_flag = 1'b1;
      end
      m_fd    = bnd;
      m_blank = !enable;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (lzModel(m_shadow, m_count / R)) m_blank = 1'b1;
`endif
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic [15:0] val);
    reset       = r;
    enable      = e;
    value_valid = v;
    value_in    = val;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic checkModel();
    checkOutput("model_digit", 16'(digit_sel), 16'(m_count / R));
    checkOutput("model_hex", 16'(hex_out), (m_shadow >> (4 * (m_count / R))) & 16'h000F);
    checkOutput("model_blank", 16'(blank), 16'(m_blank));
    checkOutput("model_frame_done", 16'(frame_done), 16'(m_fd));
  endtask

  // Step until frame_done is seen, bounded; an expired bound is a failure.
  task automatic waitFrame();
    int n;
    n = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    while (frame_done !== 1'b1 && n < 64) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      n++;
    end
    checkOutput("frame_wait", 16'(frame_done), 16'h1);
  endtask

  // Check a whole frame (16 cycles) of a steady word, starting on frame_done.
  task automatic checkFrame(input logic [15:0] word);
    for (int i = 0; i < 4 * R; i++) begin
      checkOutput("frame_digit", 16'(digit_sel), 16'(i / R));
      checkOutput("frame_hex", 16'(hex_out), (word >> (4 * (i / R))) & 16'h000F);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    end
  endtask

  initial begin
    logic       exp_bl;
    logic       r, e, v;
    logic [15:0] val;

    reset = 1'b1; enable = 1'b1; value_valid = 1'b0; value_in = 16'h0;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 3, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'hA3C7, 1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd1, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd2, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd3, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 2'd0, 4'h7, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 3, 2'd0, 4'h7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd1, 4'hC, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd2, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4, 2'd3, 4'hA, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 2'd0, 4'h7, 1'b0, 1'b0, 1'b1};

    // Reset, first frame of zeros, then A3C7 in scan order.
    for (int i = 0; i < 12; i++) begin
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      exp_bl = vecs[i].bl_lz;
`else
      exp_bl = vecs[i].bl_def;
`endif
      for (int k = 0; k < vecs[i].reps; k++) begin
        applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].vv, vecs[i].val);
        checkOutput("vec_digit", 16'(digit_sel), 16'(vecs[i].dig));
        checkOutput("vec_hex", 16'(hex_out), 16'(vecs[i].hex));
        checkOutput("vec_blank", 16'(blank), 16'(exp_bl));
        checkOutput("vec_frame_done", 16'(frame_done), 16'(vecs[i].fd));
      end
    end

    // Tear-free: FFFF on display, 1234 loaded mid-frame.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
    waitFrame();
    checkOutput("ffff_first", 16'(hex_out), 16'h000F);
    idle(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    for (int n = 0; n < 32 && frame_done !== 1'b1; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      if (frame_done !== 1'b1) checkOutput("tear_hold", 16'(hex_out), 16'h000F);
    end
    checkOutput("tear_frame", 16'(frame_done), 16'h1);
    checkFrame(16'h1234);

    // Back-to-back strobes: last one wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1111);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h2222);
    waitFrame();
    checkFrame(16'h2222);

    // Boundary collision: strobe on the boundary edge itself.
    idle(4 * R - 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hBEEF);
    checkOutput("collide_frame_done", 16'(frame_done), 16'h1);
    checkOutput("collide_digit", 16'(digit_sel), 16'h0);
    checkOutput("collide_hex", 16'(hex_out), 16'h000F);
    idle(R);
    checkOutput("collide_digit1", 16'(digit_sel), 16'h1);
    checkOutput("collide_hex1", 16'(hex_out), 16'h000E);

    // Enable pause mid-slot (slot position 1 of digit 1).
    idle(1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("pause_digit", 16'(digit_sel), 16'h1);
      checkOutput("pause_hex", 16'(hex_out), 16'h000E);
      checkOutput("pause_blank", 16'(blank), 16'h1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("resume_blank", 16'(blank), 16'h0);
    checkOutput("resume_digit_a", 16'(digit_sel), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("resume_digit_b", 16'(digit_sel), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("resume_digit_c", 16'(digit_sel), 16'h2);
    checkOutput("resume_hex_c", 16'(hex_out), 16'h000E);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042);
    waitFrame();
    for (int i = 0; i < 4 * R; i++) begin
      checkOutput("lz42_blank", 16'(blank), 16'((i / R) >= 2));
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000);
    waitFrame();
    for (int i = 0; i < 4 * R; i++) begin
      checkOutput("lz0_blank", 16'(blank), 16'((i / R) != 0));
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    end
`endif

    // Random phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) val = 16'($urandom);
      else val = 16'($urandom) >> (4 * $urandom_range(0, 3));
      applyStimulus(r, e, v, val);
      checkModel();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplex controller for the 4-digit seven-segment display. Sits directly upstream of the anode decoder.
- Drives the 2-bit digit index that the anode decoder turns into active-low anodes.
- Drives the matching 4-bit hex nibble toward the segment decoder.
- Latches new 16-bit display values tear-free, only at frame boundaries.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
- NUM_DIGITS, 4, digits per frame; fixed at 4, index width 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; low freezes scanning and blanks the display.
- value_in  input  16  four hex digits; digit 0 = [3:0], digit 3 = [15:12].
- value_valid  input  1  single-cycle strobe; captures value_in.
- digit_sel  output  2  current digit index; feeds the anode decoder's switch_in.
- hex_out  output  4  nibble of the displayed value for digit_sel.
- blank  output  1  high means the segment stage must drive all segments off.
- frame_done  output  1  one-cycle pulse when digit 3's slot ends.

Behaviour:
- Reset (synchronous, reset high at a clock edge), takes priority over everything:
  - prescaler = 0, digit_sel = 0, hex_out = 0, blank = 0, frame_done = 0.
  - shadow register = 0, pending register = 0, pending flag = 0.
  - Reset asserted mid-slot or mid-frame discards any pending value.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while enable = 1, then wraps to 0.
  - tick is high in the cycle where count == REFRESH_DIV-1 and enable = 1.
  - Counter width is $clog2(REFRESH_DIV).
- Digit scan:
  - On tick, digit_sel increments; 3 wraps to 0.
  - Frame boundary = tick while digit_sel == 3.
  - frame_done is registered: it is high for exactly the one cycle after the boundary edge, the same cycle digit_sel shows 0.
- Value capture:
  - value_valid = 1 loads the pending register from value_in and sets the pending flag.
  - Back-to-back strobes: the last one wins.
  - At a frame boundary with the flag set, shadow <= pending and the flag clears.
  - value_valid coinciding with the boundary cycle: value_in loads directly into shadow and the flag clears.
  - A value is shown starting with digit 0 of the next frame.
  - Worst-case latency: 4*REFRESH_DIV cycles.
- Output alignment:
  - hex_out is registered and updated on the same edge as digit_sel, so hex_out = shadow[4*digit_sel +: 4] at all times after reset.
  - The two outputs never disagree for any cycle.
- Enable:
  - enable = 0 holds the prescaler, digit_sel and hex_out, and sets blank = 1 (registered, one-cycle latency).
  - value_valid is still accepted into pending; no boundary occurs, so shadow does not update.
  - Re-enable continues from the held count; blank returns to 0 one cycle later.
- Scan period: digit_sel completes a full cycle in exactly 4*REFRESH_DIV enabled cycles.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - blank is also asserted for digit k whenever shadow nibbles 3..k are all zero and k != 0.
  - Digit 0 always displays.
  - Example: shadow = 16'h0042 blanks digits 3 and 2.
  - blank is registered, aligned with digit_sel and hex_out.
- Undefined: blank depends only on enable.

Decomposition:
- Package seg_pkg:
  - digit_idx_t (logic [1:0]), nibble_t (logic [3:0]).
  - NUM_DIGITS = 4.
  - Default REFRESH_DIV constant.
- Sub-module refresh_prescaler:
  - Parameter REFRESH_DIV.
  - Inputs clk, reset, enable; output tick.
  - Instantiated once.
- Remaining logic (scan counter, capture, output registers) stays in seven_seg_scanner.

Test Plan:
- Reset behaviour, REFRESH_DIV=4: hold reset 3 cycles with value_valid pulsing → all outputs 0; shadow stays 0 after release; first digit_sel change 4 cycles after release.
- Scan order, REFRESH_DIV=4, value 16'hA3C7 loaded before the first boundary: from the next frame → (digit_sel, hex_out) = (0,7), (1,C), (2,3), (3,A), each for 4 cycles; frame_done pulses every 16 cycles.
- Tear-free update: load 16'h1234 mid-frame while 16'hFFFF is displayed → remaining slots still show F; the next frame shows 4, 3, 2, 1; strobes 16'h1111 then 16'h2222 in one frame → only 2222 is shown.
- Boundary collision: value_valid with 16'hBEEF in the boundary cycle → next frame digit 0 shows F, with no extra frame delay.
- Enable pause: drop enable for 10 cycles mid-slot → digit_sel and hex_out frozen, blank = 1 one cycle later; resume → the slot completes its remaining count, blank = 0.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined and shadow = 16'h0042 → blank = 1 on digits 3 and 2, 0 on digits 1 and 0; shadow = 0 → only digit 0 unblanked.
